cle_stats: RTL and testbench

- Downstream consumer of the connected-component labeling stage.
- Scans the 32x32 label map (1024 bytes, address = y*32+x) that the labeling stage has written into SRAM.
- Accumulates per-label pixel count and bounding box, then streams one record per non-empty label over a valid/ready interface.
- Started by the labeling stage's finish pulse; owns the SRAM read address only while busy.

---
 rtl/cle_stats_pkg.sv | 28 ++
 rtl/cle_stats_bank.sv | 53 +++++
 rtl/cle_stats.sv | 128 ++++++++++++
 tb/tb_cle_stats.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cle_stats_pkg.sv
// Shared types and widths for the label-statistics stage.
package cle_stats_pkg;

  localparam int unsigned IMG_W_LOG2 = 5;
  localparam int unsigned ADDR_W     = 2 * IMG_W_LOG2;
  localparam int unsigned COORD_W    = IMG_W_LOG2;
  localparam int unsigned CNT_W      = ADDR_W + 1;
  localparam int unsigned LABEL_W    = 8;
  localparam int unsigned X_LSB      = 0;
  localparam int unsigned Y_LSB      = IMG_W_LOG2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_EMIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0]   count;
    logic [COORD_W-1:0] xmin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] ymin;
    logic [COORD_W-1:0] ymax;
  } stat_t;

endpackage

// File: rtl/cle_stats_bank.sv
// Per-label statistics storage: pixel count plus inclusive bounding box.
module cle_stats_bank
  import cle_stats_pkg::*;
#(
  parameter int unsigned MAX_LABELS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               upd_en,
  input  logic [LABEL_W-1:0] upd_label,
  input  logic [COORD_W-1:0] upd_x,
  input  logic [COORD_W-1:0] upd_y,
  input  logic [LABEL_W-1:0] rd_label,
  output stat_t              rd
);

  stat_t ent [MAX_LABELS];

  // Entry j holds label j+1; the first pixel of a label seeds its box.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < int'(MAX_LABELS); j++) ent[j] <= '0;
    end else if (clear) begin
      for (int j = 0; j < int'(MAX_LABELS); j++) ent[j] <= '0;
    end else if (upd_en) begin
      for (int j = 0; j < int'(MAX_LABELS); j++) begin
        if (upd_label == LABEL_W'(j + 1)) begin
          if (ent[j].count == '0) begin
            ent[j].xmin <= upd_x;
            ent[j].xmax <= upd_x;
            ent[j].ymin <= upd_y;
            ent[j].ymax <= upd_y;
          end else begin
            if (upd_x < ent[j].xmin) ent[j].xmin <= upd_x;
            if (upd_x > ent[j].xmax) ent[j].xmax <= upd_x;
            if (upd_y < ent[j].ymin) ent[j].ymin <= upd_y;
            if (upd_y > ent[j].ymax) ent[j].ymax <= upd_y;
          end
          ent[j].count <= ent[j].count + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int j = 0; j < int'(MAX_LABELS); j++) begin
      if (rd_label == LABEL_W'(j + 1)) rd = ent[j];
    end
  end

endmodule

// File: rtl/cle_stats.sv
// Scans the label map in SRAM, accumulates per-label stats and streams one record per label.
module cle_stats
  import cle_stats_pkg::*;
#(
  parameter int unsigned MAX_LABELS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LABEL_W-1:0] sram_q,
  output logic [ADDR_W-1:0]  sram_a,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LABEL_W-1:0] out_label,
  output logic [CNT_W-1:0]   out_count,
  output logic [COORD_W-1:0] out_xmin,
  output logic [COORD_W-1:0] out_xmax,
  output logic [COORD_W-1:0] out_ymin,
  output logic [COORD_W-1:0] out_ymax,
  output logic               overflow,
  output logic               done
);

  state_t             state;
  logic [ADDR_W-1:0]  addr_q;
  logic               scan_q;
  logic [LABEL_W-1:0] idx;
  stat_t              rd;

  logic clear_c, upd_en_c, ovf_c, last_c;

  assign clear_c  = (state == ST_IDLE) && start;
  assign upd_en_c = scan_q && (sram_q != '0) && (sram_q <= LABEL_W'(MAX_LABELS));
  assign ovf_c    = scan_q && (sram_q > LABEL_W'(MAX_LABELS));
  assign last_c   = (idx == LABEL_W'(MAX_LABELS));

  cle_stats_bank #(.MAX_LABELS(MAX_LABELS)) u_bank (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_c),
    .upd_en    (upd_en_c),
    .upd_label (sram_q),
    .upd_x     (addr_q[X_LSB +: COORD_W]),
    .upd_y     (addr_q[Y_LSB +: COORD_W]),
    .rd_label  (idx),
    .rd        (rd)
  );

  // addr_q/scan_q tag the byte returning one cycle after its address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      sram_a    <= '0;
      addr_q    <= '0;
      scan_q    <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_label <= '0;
      out_count <= '0;
      out_xmin  <= '0;
      out_xmax  <= '0;
      out_ymin  <= '0;
      out_ymax  <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      scan_q <= (state == ST_SCAN);
      addr_q <= sram_a;
      done   <= 1'b0;
      if (ovf_c) overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SCAN;
            sram_a   <= '0;
            busy     <= 1'b1;
            overflow <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (sram_a == '1) state <= ST_DRAIN;
          else sram_a <= sram_a + ADDR_W'(1);
        end
        ST_DRAIN: begin
          state <= ST_EMIT;
          idx   <= LABEL_W'(1);
        end
        // A non-empty label is loaded into the output registers, then held until accepted.
        ST_EMIT: begin
          if (out_valid) begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (last_c) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                idx <= idx + LABEL_W'(1);
              end
            end
          end else if (rd.count == '0) begin
            if (last_c) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              idx <= idx + LABEL_W'(1);
            end
          end else begin
            out_valid <= 1'b1;
            out_label <= idx;
            out_count <= rd.count;
            out_xmin  <= rd.xmin;
            out_xmax  <= rd.xmax;
            out_ymin  <= rd.ymin;
            out_ymax  <= rd.ymax;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cle_stats.sv
// Directed bench for cle_stats with a 1-cycle-latency SRAM model and record collection.
module tb_cle_stats;

  typedef struct packed {
    logic [7:0]  label;
    logic [10:0] count;
    logic [4:0]  xmin;
    logic [4:0]  xmax;
    logic [4:0]  ymin;
    logic [4:0]  ymax;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  sram_q;
  logic [9:0]  sram_a;
  logic        busy, out_valid, out_ready, overflow, done;
  logic [7:0]  out_label;
  logic [10:0] out_count;
  logic [4:0]  out_xmin, out_xmax, out_ymin, out_ymax;

  logic [7:0]  mem [1024];

  int checks = 0;
  int failures = 0;
  rec_t recs[$];
  int addr_err, busy_err, unstable, stall_samples, done_at;

  always #5 clk = ~clk;

  always @(posedge clk) sram_q <= mem[sram_a];

  cle_stats #(.MAX_LABELS(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sram_q    (sram_q),
    .sram_a    (sram_a),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_label (out_label),
    .out_count (out_count),
    .out_xmin  (out_xmin),
    .out_xmax  (out_xmax),
    .out_ymin  (out_ymin),
    .out_ymax  (out_ymax),
    .overflow  (overflow),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rec_t mk(input int l, input int c, input int x0, input int x1,
                              input int y0, input int y1);
    rec_t r;
    r.label = 8'(l);  r.count = 11'(c);
    r.xmin  = 5'(x0); r.xmax  = 5'(x1);
    r.ymin  = 5'(y0); r.ymax  = 5'(y1);
    return r;
  endfunction

  function automatic rec_t cur_rec();
    return {out_label, out_count, out_xmin, out_xmax, out_ymin, out_ymax};
  endfunction

  function automatic rec_t rec_at(input int i);
    return (i < recs.size()) ? recs[i] : '0;
  endfunction

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 1024; i++) mem[i] = v;
  endtask

  // Pulses start, follows the scan cycle by cycle (c = cycles after acceptance), collects records.
  task automatic run_scan(input int stall, input bit repulse);
    rec_t held, cur;
    bit   holding;
    int   stall_left;
    recs.delete();
    addr_err = 0; busy_err = 0; unstable = 0; stall_samples = 0; done_at = -1;
    holding = 1'b0; stall_left = stall;
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 3000; c++) begin
      start = repulse && (c == 100);
      if (c <= 1024 && sram_a !== 10'(c - 1)) addr_err++;
      if (busy !== 1'b1) busy_err++;
      if (done === 1'b1) begin
        done_at = c;
        break;
      end
      if (out_valid === 1'b1) begin
        cur = cur_rec();
        if (!holding) begin
          held = cur;
          holding = 1'b1;
        end else if (cur !== held) begin
          unstable++;
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          stall_samples++;
        end else begin
          out_ready = 1'b1;
          recs.push_back(cur);
          stall_left = stall;
          holding = 1'b0;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("done_seen", 64'(done_at >= 0), 64'd1);
    @(negedge clk);
    check("done_one_cycle", {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int waited;
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    fill(8'd0);
    repeat (3) @(negedge clk);
    check("rst_sram_a", 64'(sram_a), 64'd0);
    check("rst_flags", {59'd0, busy, out_valid, overflow, done, 1'b0}, 64'd0);
    check("rst_rec", 64'(cur_rec()), 64'd0);
    reset = 1'b1;

    // Single pixel of label 1 at (5,1)
    fill(8'd0); mem[37] = 8'd1;
    run_scan(0, 1'b0);
    check("a_nrec", 64'(recs.size()), 64'd1);
    check("a_rec", 64'(rec_at(0)), 64'(mk(1, 1, 5, 5, 1, 1)));
    check("a_addr_seq", 64'(addr_err), 64'd0);
    check("a_busy", 64'(busy_err), 64'd0);
    check("a_ovf", 64'(overflow), 64'd0);

    // Full image of label 3
    fill(8'd3);
    run_scan(0, 1'b0);
    check("b_nrec", 64'(recs.size()), 64'd1);
    check("b_rec", 64'(rec_at(0)), 64'(mk(3, 1024, 0, 31, 0, 31)));

    // Two labels with backpressure, second label in the final address
    fill(8'd0);
    for (int i = 0; i < 4; i++) mem[i] = 8'd1;
    mem[1023] = 8'd2;
    run_scan(5, 1'b0);
    check("c_nrec", 64'(recs.size()), 64'd2);
    check("c_rec0", 64'(rec_at(0)), 64'(mk(1, 4, 0, 3, 0, 0)));
    check("c_rec1", 64'(rec_at(1)), 64'(mk(2, 1, 31, 31, 31, 31)));
    check("c_stall", 64'(stall_samples), 64'd10);
    check("c_stable", 64'(unstable), 64'd0);

    // Out-of-range label only: overflow, no records, fixed done timing
    fill(8'd0); mem[200] = 8'd40;
    run_scan(0, 1'b0);
    check("d_nrec", 64'(recs.size()), 64'd0);
    check("d_ovf", 64'(overflow), 64'd1);
    check("d_done_at", 64'(done_at), 64'd1058);

    // Abort mid-scan with reset, then rescan a different image
    fill(8'd9);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    waited = 0;
    while (sram_a !== 10'd500 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("e_reach_500", 64'(waited < 2000), 64'd1);
    reset = 1'b0;
    #1;
    check("e_abort_flags", {61'd0, busy, out_valid, done}, 64'd0);
    check("e_abort_addr", 64'(sram_a), 64'd0);
    @(negedge clk); reset = 1'b1;
    fill(8'd0); mem[0] = 8'd5;
    run_scan(0, 1'b0);
    check("e_nrec", 64'(recs.size()), 64'd1);
    check("e_rec", 64'(rec_at(0)), 64'(mk(5, 1, 0, 0, 0, 0)));

    // Overflow from the earlier scan was cleared by a fresh start; then start re-pulsed in SCAN
    fill(8'd0); mem[37] = 8'd1;
    run_scan(0, 1'b1);
    check("f_ovf_clear", 64'(overflow), 64'd0);
    check("f_addr_seq", 64'(addr_err), 64'd0);
    check("f_nrec", 64'(recs.size()), 64'd1);
    check("f_rec", 64'(rec_at(0)), 64'(mk(1, 1, 5, 5, 1, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
